regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of register_file_8x16 among NREQ requesters.
//  Each requester uses a valid/ready handshake. An accepted write is registered and driven onto
//  rf_wr_en/rf_wr_addr/rf_wr_data one cycle later.
//  Optional per-requester lock holds the grant for multi-write bursts.
//  Writes to address 0 are absorbed here and counted; register 0 is hardwired zero.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  AW     3   register address width
//  DW     16  register data width
//  CNTW   8   width of dropped-write counter
// PORTS
//  clk           in   1          clock, rising edge
//  rst_n         in   1          synchronous reset, active-low
//  req_valid     in   NREQ       requester i has a write pending
//  req_lock      in   NREQ       keep grant after this write (burst)
//  req_addr      in   NREQ*AW    write address, requester i at [i*AW +: AW]
//  req_data      in   NREQ*DW    write data, requester i at [i*DW +: DW]
//  req_ready     out  NREQ       one-hot (or zero) accept; transfer = valid & ready
//  rf_wr_en      out  1          write strobe to register file
//  rf_wr_addr    out  AW         write address to register file
//  rf_wr_data    out  DW         write data to register file
//  grant_id      out  clog2(NREQ) index of last accepted requester (registered)
//  locked        out  1          arbiter is in LOCKED state
//  drop_cnt      out  CNTW       saturating count of address-0 writes dropped
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge) sets rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, locked=0,
//   drop_cnt=0, rr pointer=0, state=ARB. req_ready is combinational and is 0 during reset.
//  FSM states:
//   ARB    : winner = first i with req_valid[i], scanning from ptr upward modulo NREQ.
//            req_ready[winner]=1; all other ready bits are 0. No valid -> ready all 0.
//   LOCKED : req_ready[owner]=req_valid[owner]; all other ready bits are 0.
//  Transitions, evaluated on each accepted transfer by requester w:
//   req_lock[w]=1                  -> LOCKED, owner=w, ptr unchanged
//   req_lock[w]=0                  -> ARB, ptr=(w+1) mod NREQ
//  In LOCKED with req_valid[owner]=0 -> stay LOCKED (owner keeps the grant; no timeout).
//  Output stage (1-cycle latency, throughput 1 write/cycle, no backpressure from register file):
//   transfer at edge N -> in cycle N+1: rf_wr_addr/rf_wr_data = accepted values, grant_id=w.
//   rf_wr_en=1 only if addr!=0. If addr==0, rf_wr_en=0 and drop_cnt+=1, saturating at 2^CNTW-1.
//   No transfer -> rf_wr_en=0; addr/data/grant_id hold their last values.
//  Simultaneous valids: exactly one is accepted per cycle; the losers' valid/addr/data must stay
//   stable until accepted (requester obligation; checked by assertion in the bench).
//  Reset mid-operation: a pending registered write is discarded (rf_wr_en=0 the next cycle).
//   The lock is released.
//  A burst is not interleaved with other writes. Fairness: with all valid, each requester gets
//   exactly one grant in any NREQ consecutive unlocked grants.
//  Pointer wrap: ptr=NREQ-1 after a grant to NREQ-2; a grant to NREQ-1 sets ptr=0.
//  No combinational path from rf_* outputs back to req_ready.
// TESTING
//  1. Reset, then req_valid=0001, addr=3, data=BEEF -> ready=0001 same cycle; next cycle
//     rf_wr_en=1, addr=3, data=BEEF; register file readback of reg3 = BEEF.
//  2. All four valid continuously, lock=0 -> grant order 0,1,2,3,0,1,...
//     One rf_wr_en pulse per cycle.
//  3. Req1 writes addr=0, data=DEAD -> rf_wr_en stays 0, drop_cnt 0->1; reg0 reads 0000.
//     Repeat 300 times -> drop_cnt=255, saturated.
//  4. Req2 lock=1 for 3 writes (addrs 5,6,7), then lock=0; req0 valid throughout
//     -> 4 consecutive req2 grants, locked=1 between them, then req0 is granted.
//  5. Req3 locked, then drops valid for 5 cycles while req1 is valid -> req1 never readied;
//     req3 resumes and completes.
//  6. rst_n=0 asserted the cycle after a transfer -> rf_wr_en=0, locked=0, ptr=0;
//     the first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for an 8x16 register file.
// Requesters use valid/ready; one write is accepted per cycle and presented
// to the register file one cycle later. A requester may lock the grant for a
// burst. Writes to address 0 are dropped here and counted.
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16,
    parameter int CNTW = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_lock,
    input  logic [NREQ*AW-1:0]            req_addr,
    input  logic [NREQ*DW-1:0]            req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          rf_wr_en,
    output logic [AW-1:0]                 rf_wr_addr,
    output logic [DW-1:0]                 rf_wr_data,
    output logic [$clog2(NREQ)-1:0]       grant_id,
    output logic                          locked,
    output logic [CNTW-1:0]               drop_cnt
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] owner, owner_nxt;

    logic           xfer;
    logic [IDW-1:0] win;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_data;

    // Winner selection, ready generation and next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_ready = '0;
        xfer      = 1'b0;
        win       = '0;
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;

        if (rst_n) begin
            if (state == LOCKED) begin
                // Owner keeps the grant even while idle; nobody else is served.
                if (req_valid[owner]) begin
                    xfer = 1'b1;
                    win  = owner;
                end
            end else begin
                // First valid requester at or after ptr, wrapping modulo NREQ.
                for (int k = 0; k < NREQ; k++) begin
                    if (!xfer && req_valid[(int'(ptr) + k) % NREQ]) begin
                        xfer = 1'b1;
                        win  = IDW'((int'(ptr) + k) % NREQ);
                    end
                end
            end

            if (xfer) begin
                req_ready[win] = 1'b1;
                if (req_lock[win]) begin
                    state_nxt = LOCKED;
                    owner_nxt = win;
                end else begin
                    state_nxt = ARB;
                    ptr_nxt   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
        end
    end

    assign win_addr = req_addr[win*AW +: AW];
    assign win_data = req_data[win*DW +: DW];
    assign locked   = (state == LOCKED);

    // Arbitration state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Registered write stage toward the register file, plus the drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            grant_id   <= '0;
            drop_cnt   <= '0;
        end else begin
            rf_wr_en <= 1'b0;
            if (xfer) begin
                rf_wr_addr <= win_addr;
                rf_wr_data <= win_data;
                grant_id   <= win;
                // Register 0 is hardwired zero, so its writes never reach the file.
                rf_wr_en   <= (win_addr != '0);
                if (win_addr == '0 && drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 16;
    localparam int CNTW = 8;
    localparam int IDW  = 2;
    localparam int SAT  = (1 << CNTW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NREQ-1:0]     v  = '0;
    logic [NREQ-1:0]     lk = '0;
    logic [AW-1:0]       a [NREQ];
    logic [DW-1:0]       d [NREQ];

    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rf_wr_en;
    logic [AW-1:0]       rf_wr_addr;
    logic [DW-1:0]       rf_wr_data;
    logic [IDW-1:0]      grant_id;
    logic                locked;
    logic [CNTW-1:0]     drop_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = a[g];
        assign req_data[g*DW +: DW] = d[g];
    end

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v),
        .req_lock   (lk),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .grant_id   (grant_id),
        .locked     (locked),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shadow register file fed by the DUT write port.
    logic [DW-1:0] shadow [8];
    initial for (int i = 0; i < 8; i++) shadow[i] = '0;
    always @(posedge clk) if (rf_wr_en === 1'b1) shadow[rf_wr_addr] <= rf_wr_data;

    // Behavioural model: current (m_) and next (n_) values.
    int          m_ptr = 0, m_owner = 0, m_gid = 0, m_drop = 0;
    bit          m_lockd = 0, m_en = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int          n_ptr = 0, n_owner = 0, n_gid = 0, n_drop = 0;
    bit          n_lockd = 0, n_en = 0;
    logic [AW-1:0] n_addr = '0;
    logic [DW-1:0] n_data = '0;
    int          last_acc = -1;

    // Requester-obligation snapshot.
    bit              p_rst = 0;
    int              p_acc = -1;
    logic [NREQ-1:0] p_v, p_lk;
    logic [AW-1:0]   p_a [NREQ];
    logic [DW-1:0]   p_d [NREQ];

    // Compare process: checks DUT against the model away from the active edge.
    always @(negedge clk) begin : cmp
        int w;
        logic [NREQ-1:0] er;
        w  = -1;
        er = '0;
        if (rst_n === 1'b1) begin
            if (m_lockd) begin
                if (v[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) er[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("rf_wr_en", 32'(rf_wr_en), 32'(m_en));
        check("rf_wr_addr", 32'(rf_wr_addr), 32'(m_addr));
        check("rf_wr_data", 32'(rf_wr_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("locked", 32'(locked), 32'(m_lockd));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));

        n_ptr = m_ptr; n_owner = m_owner; n_gid = m_gid; n_drop = m_drop;
        n_lockd = m_lockd; n_en = 1'b0; n_addr = m_addr; n_data = m_data;
        if (rst_n !== 1'b1) begin
            n_ptr = 0; n_owner = 0; n_gid = 0; n_drop = 0;
            n_lockd = 0; n_addr = '0; n_data = '0;
        end else if (w >= 0) begin
            n_addr = a[w];
            n_data = d[w];
            n_gid  = w;
            n_en   = (a[w] != 0);
            if (a[w] == 0 && m_drop < SAT) n_drop = m_drop + 1;
            if (lk[w]) begin
                n_lockd = 1; n_owner = w;
            end else begin
                n_lockd = 0; n_ptr = (w + 1) % NREQ;
            end
        end

        if (p_rst && rst_n === 1'b1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (p_v[i] && p_acc != i)
                    assert (v[i] && lk[i] == p_lk[i] && a[i] == p_a[i] && d[i] == p_d[i])
                    else $error("requester %0d changed a pending request", i);
            end
        end
        p_rst = (rst_n === 1'b1);
        p_acc = w;
        p_v   = v;
        p_lk  = lk;
        for (int i = 0; i < NREQ; i++) begin
            p_a[i] = a[i];
            p_d[i] = d[i];
        end
        last_acc = w;
    end

    always @(posedge clk) begin
        m_ptr = n_ptr; m_owner = n_owner; m_gid = n_gid; m_drop = n_drop;
        m_lockd = n_lockd; m_en = n_en; m_addr = n_addr; m_data = n_data;
    end

    // One cycle; an accepted request is withdrawn afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        if (last_acc >= 0) v[last_acc] = 1'b0;
    endtask

    task automatic post(input int i, input bit l, input int ad, input int da);
        v[i]  = 1'b1;
        lk[i] = l;
        a[i]  = AW'(ad);
        d[i]  = DW'(da);
    endtask

    task automatic expect_ready(input string name, input logic [NREQ-1:0] exp);
        #1;
        check(name, 32'(req_ready), 32'(exp));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        v     = '0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end

        // Reset state and ready gating during reset.
        do_reset(3);
        rst_n = 1'b0;
        v = '1;
        expect_ready("ready_in_reset", 4'b0000);
        v = '0;
        rst_n = 1'b1;
        check("rst_en", 32'(rf_wr_en), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_gid", 32'(grant_id), 0);

        // 1: single write, one-cycle latency, readback.
        post(0, 0, 3, 'hBEEF);
        expect_ready("t1_ready", 4'b0001);
        step();
        check("t1_en", 32'(rf_wr_en), 1);
        check("t1_addr", 32'(rf_wr_addr), 3);
        check("t1_data", 32'(rf_wr_data), 'hBEEF);
        step();
        check("t1_reg3", 32'(shadow[3]), 'hBEEF);

        // 2: all valid, no lock -> strict rotation, one write per cycle.
        do_reset(2);
        for (int i = 0; i < NREQ; i++) post(i, 0, i + 1, $urandom);
        for (int k = 0; k < 8; k++) begin
            expect_ready("t2_ready", 4'(1 << (k % NREQ)));
            step();
            check("t2_en", 32'(rf_wr_en), 1);
            check("t2_gid", 32'(grant_id), 32'(k % NREQ));
            for (int i = 0; i < NREQ; i++) if (!v[i]) post(i, 0, i + 1, $urandom);
        end

        // 3: address-0 writes are dropped and counted, saturating.
        do_reset(2);
        post(1, 0, 0, 'hDEAD);
        step();
        check("t3_en", 32'(rf_wr_en), 0);
        check("t3_drop1", 32'(drop_cnt), 1);
        repeat (300) begin
            post(1, 0, 0, $urandom);
            step();
        end
        check("t3_drop_sat", 32'(drop_cnt), 255);
        check("t3_reg0", 32'(shadow[0]), 0);

        // 4: locked burst of four from req2 is not interleaved with req0.
        do_reset(2);
        post(2, 1, 5, 'h2005);
        expect_ready("t4_ready0", 4'b0100);
        step();
        check("t4_locked0", 32'(locked), 1);
        post(0, 0, 1, 'h1111);
        post(2, 1, 6, 'h2006);
        expect_ready("t4_ready1", 4'b0100);
        step();
        check("t4_locked1", 32'(locked), 1);
        post(2, 1, 7, 'h2007);
        expect_ready("t4_ready2", 4'b0100);
        step();
        check("t4_locked2", 32'(locked), 1);
        post(2, 0, 4, 'h2004);
        expect_ready("t4_ready3", 4'b0100);
        step();
        check("t4_unlocked", 32'(locked), 0);
        expect_ready("t4_req0", 4'b0001);
        step();
        check("t4_gid0", 32'(grant_id), 0);

        // 5: idle lock owner starves others until it resumes.
        do_reset(2);
        post(3, 1, 2, 'h3333);
        expect_ready("t5_ready3", 4'b1000);
        step();
        post(1, 0, 3, 'h1313);
        repeat (5) begin
            expect_ready("t5_starve", 4'b0000);
            check("t5_locked", 32'(locked), 1);
            step();
        end
        post(3, 0, 4, 'h3434);
        expect_ready("t5_resume", 4'b1000);
        step();
        expect_ready("t5_req1", 4'b0010);
        step();

        // 6: reset the cycle after a locked transfer.
        do_reset(2);
        post(2, 1, 5, 'h5555);
        expect_ready("t6_ready", 4'b0100);
        step();
        check("t6_en", 32'(rf_wr_en), 1);
        check("t6_locked", 32'(locked), 1);
        rst_n = 1'b0;
        v = '0;
        expect_ready("t6_ready_rst", 4'b0000);
        step();
        check("t6_en_rst", 32'(rf_wr_en), 0);
        check("t6_locked_rst", 32'(locked), 0);
        rst_n = 1'b1;
        post(1, 0, 1, 'h0101);
        post(3, 0, 3, 'h0303);
        expect_ready("t6_lowest", 4'b0010);
        step();
        check("t6_gid", 32'(grant_id), 1);

        // Randomized traffic; the compare process checks every cycle.
        do_reset(2);
        repeat (3000) begin
            if ($urandom_range(199, 0) == 0) begin
                rst_n = 1'b0;
                v = '0;
            end else begin
                rst_n = 1'b1;
                for (int i = 0; i < NREQ; i++)
                    if (!v[i] && $urandom_range(1, 0) == 1)
                        post(i, $urandom_range(3, 0) == 0, $urandom_range(7, 0), $urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
